uart_rx_param: RTL
==================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver and LED command sink; next generation of the fixed 8N1 fpga_uart_rx.
//  Oversamples the async rx line, validates start/parity/stop, presents bytes on a valid/ready port.
//  Flags framing, parity and overrun errors; mirrors each good byte's low bits onto an LED register.
//  Sits between the board UART pin and the sensor/LED control logic.
// PARAMETERS
//  CLK_FREQ    100_000_000  system clock frequency, Hz
//  BAUD_RATE   115_200      line rate, bit/s
//  OVERSAMPLE  16           sample ticks per bit; even, >=8
//  DATA_BITS   8            payload bits per frame, 5..9, LSB first
//  PARITY      0            0 none, 1 odd, 2 even
//  NUM_LEDS    6            LED outputs; must be <= DATA_BITS
// PORTS
//  clk          in   1          system clock; all logic on posedge
//  rst          in   1          synchronous, active-high reset
//  uart_rx      in   1          async serial line, idle high
//  rx_data      out  DATA_BITS  received payload; stable while rx_valid=1
//  rx_valid     out  1          payload available; held until accepted
//  rx_ready     in   1          consumer accepts when rx_valid && rx_ready
//  err_frame    out  1          1-cycle pulse: stop bit sampled low
//  err_parity   out  1          1-cycle pulse: parity mismatch
//  err_overrun  out  1          1-cycle pulse: good frame dropped, buffer full
//  led          out  NUM_LEDS   LED register, 1 = on
// BEHAVIOUR
//  - Reset: all outputs 0; sync flops and sampled line = 1; FSM IDLE; tick divider cleared.
//    Reset mid-frame abandons the frame with no error pulse.
//  - Synchroniser: uart_rx passes 2 flops before any use (2-cycle input latency).
//  - Tick: DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), truncated (54 at defaults).
//    Free-running counter 0..DIV-1, 1-cycle tick at DIV-1.
//    Bit period = DIV*OVERSAMPLE clocks (864 at defaults).
//  - FSM; s_cnt counts ticks within a bit:
//    IDLE     : synced line 0 -> START, s_cnt=0.
//    START    : at s_cnt = OVERSAMPLE/2-1: line 0 -> DATA; line 1 -> IDLE (glitch, no flag).
//    DATA     : sample every OVERSAMPLE ticks, shift LSB-first; after DATA_BITS samples -> PARITY,
//               or STOP when PARITY=0.
//    PARITY   : one sample, compared against XOR of data (odd: XOR^1).
//    STOP     : one sample.
//               Line 1, parity good -> frame good -> IDLE.
//               Line 1, parity bad  -> err_parity -> IDLE.
//               Line 0 -> err_frame (overrides parity) -> WAIT_HI.
//    WAIT_HI  : stay until synced line 1 (break handling), then IDLE.
//  - Good frame, one cycle after the stop sample:
//    led <= data[NUM_LEDS-1:0], regardless of handshake state.
//    Buffer empty, or rx_ready=1 that same cycle -> rx_data loaded, rx_valid=1.
//    Otherwise err_overrun pulses, old rx_data/rx_valid kept, new payload dropped.
//  - Errored frames never touch rx_data, rx_valid or led.
//  - rx_valid clears the cycle after accept, unless a good frame reloads it in the same cycle.
//  - Only one stop bit is checked; extra stop bits read as idle.
//  - Error pulses are exactly 1 cycle, at most one per frame.
// STRUCTURE
//  - uart_pkg (shared): rx_state_t enum {IDLE, START, DATA, PARITY, STOP, WAIT_HI};
//    PAR_NONE/PAR_ODD/PAR_EVEN localparams; function calc_div(clk, baud, os).
//  - Sub-module uart_baud_tick (DIV parameter; clk, rst -> tick). Shared later with the UART tx.
//  - Synchroniser, FSM, shift register, output buffer and LED register live in this module.
// TESTING (defaults unless stated; bench bit period = 864 clk; rx_ready=1 unless stated)
//  1. Send 0x01, 8N1 -> rx_valid with rx_data=0x01; led=6'b000001; no error pulses.
//  2. Send 0x02, then 0x3F -> led 6'b000010, then 6'b111111; two rx_valid handshakes.
//  3. Send 0xA5 with stop bit driven 0 for 2 bit periods -> err_frame 1 cycle, no rx_valid,
//     led unchanged; next 0x04 received normally.
//  4. PARITY=2: 0x03 with parity bit 0 -> accepted. Same byte with parity bit 1 ->
//     err_parity, no rx_valid, led unchanged.
//  5. rx_ready=0: send 0x11, then 0x22 -> err_overrun on 2nd; rx_data stays 0x11;
//     led=0x22[5:0]=6'b100010.
//  6. Line low 200 clk then high -> no state change, no pulses.
//     rst high mid-DATA of 0x55 -> outputs 0, then next 0x0F received cleanly.

Source files
------------

// File: rtl/uart_rx_param_pkg.sv
// rtl/uart_rx_param_pkg.sv - shared UART receiver types, parity codes and baud divider helper
//
// Purpose:
//   Common definitions for the UART receiver and its baud tick generator.
//   The transmitter is expected to import the same package later.
// Contents:
//   rx_state_t  receiver state encoding (IDLE, START, DATA, PARITY, STOP, WAIT_HI)
//   PAR_*       parity mode codes used by the PARITY parameter
//   calc_div    clocks per oversample tick, truncated
package uart_rx_param_pkg;

  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    RX_START   = 3'd1,
    RX_DATA    = 3'd2,
    RX_PARITY  = 3'd3,
    RX_STOP    = 3'd4,
    RX_WAIT_HI = 3'd5
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Integer division truncates, so the real baud rate runs slightly fast;
  // sampling at mid-bit leaves plenty of margin for that error.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - received byte stream with valid/ready handshake
//
// Purpose:
//   Carries received payloads from the UART receiver to its consumer.
// Signals:
//   rx_data   payload, stable while rx_valid is high
//   rx_valid  payload available, held until accepted
//   rx_ready  consumer accepts when rx_valid && rx_ready
// Modports:
//   master    byte producer (the receiver)
//   slave     byte consumer
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_param_baud_tick.sv
// rtl/uart_rx_param_baud_tick.sv - free-running oversample tick generator
//
// Purpose:
//   Divides the system clock by DIV and emits a one-cycle tick on the last
//   count. Runs continuously so rx and tx can share the same timebase.
// Ports:
//   i_clk   system clock
//   i_rst   synchronous active-high reset, clears the divider
//   o_tick  one-cycle pulse every DIV clocks (every cycle when DIV = 1)
module uart_rx_param_baud_tick #(
  parameter int DIV = 54
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampling UART receiver with valid/ready output and LED mirror
//
// Purpose:
//   Synchronises the asynchronous rx line, finds start bits, samples each bit
//   at its centre, checks parity and stop, and offers good payloads on a
//   valid/ready stream. The low bits of every good payload drive an LED register.
// Ports:
//   i_clk          system clock, all logic on posedge
//   i_rst          synchronous active-high reset
//   i_uart_rx      asynchronous serial line, idle high
//   rx_if          master side of the byte stream (rx_data/rx_valid out, rx_ready in)
//   o_err_frame    1-cycle pulse: stop bit sampled low
//   o_err_parity   1-cycle pulse: parity mismatch
//   o_err_overrun  1-cycle pulse: good payload dropped, buffer still full
//   o_led          LED register, 1 = on
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PAR_NONE,
  parameter int NUM_LEDS   = 6
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_uart_rx,
  uart_rx_param_if.master     rx_if,
  output logic                o_err_frame,
  output logic                o_err_parity,
  output logic                o_err_overrun,
  output logic [NUM_LEDS-1:0] o_led
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);

  localparam logic [SCW-1:0] HALF_LAST = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] FULL_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE    = RX_IDLE;
  localparam logic [2:0] S_START   = RX_START;
  localparam logic [2:0] S_DATA    = RX_DATA;
  localparam logic [2:0] S_PARITY  = RX_PARITY;
  localparam logic [2:0] S_STOP    = RX_STOP;
  localparam logic [2:0] S_WAIT_HI = RX_WAIT_HI;

  generate
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
      $error("uart_rx_param: OVERSAMPLE must be even and >= 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
      $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if (NUM_LEDS < 1 || NUM_LEDS > DATA_BITS) begin : g_bad_leds
      $error("uart_rx_param: NUM_LEDS must be 1..DATA_BITS");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_par
      $error("uart_rx_param: PARITY must be 0, 1 or 2");
    end
    if (DIV < 1) begin : g_bad_div
      $error("uart_rx_param: clock too slow for BAUD_RATE*OVERSAMPLE");
    end
  endgenerate

  logic                 r_sync1;
  logic                 r_sync2;
  logic [2:0]           r_state;
  logic [SCW-1:0]       r_s_cnt;
  logic [BCW-1:0]       r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_good;
  logic                 r_err_frame;
  logic                 r_err_parity;
  logic                 r_err_overrun;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic [NUM_LEDS-1:0]  r_led;

  logic w_tick;
  logic w_line;
  logic w_par_exp;
  logic w_par_ok;
  logic w_accept;

  uart_rx_param_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (w_tick)
  );

  // Two-flop synchroniser; both flops reset to the idle (high) line level so
  // a reset never looks like a start bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_line = r_sync2;

  // Odd parity expects the XOR of data inverted; with no parity the check passes.
  assign w_par_exp = (^r_shift) ^ (PARITY == PAR_ODD);
  assign w_par_ok  = (PARITY == PAR_NONE) || (r_par_bit == w_par_exp);

  // Frame FSM. The start bit is confirmed half a bit in, which also places
  // every later sample (one full bit apart) at the bit centre.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_s_cnt      <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_bit    <= 1'b0;
      r_good       <= 1'b0;
      r_err_frame  <= 1'b0;
      r_err_parity <= 1'b0;
    end else begin
      r_good       <= 1'b0;
      r_err_frame  <= 1'b0;
      r_err_parity <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_line) begin
            r_state <= S_START;
            r_s_cnt <= '0;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (r_s_cnt == HALF_LAST) begin
              r_s_cnt   <= '0;
              r_bit_cnt <= '0;
              // A line back high at mid-start was a glitch; drop it silently.
              r_state   <= w_line ? S_IDLE : S_DATA;
            end else begin
              r_s_cnt <= r_s_cnt + SCW'(1);
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_s_cnt == FULL_LAST) begin
              r_s_cnt <= '0;
              r_shift <= {w_line, r_shift[DATA_BITS-1:1]};
              if (r_bit_cnt == BIT_LAST) begin
                r_state <= (PARITY == PAR_NONE) ? S_STOP : S_PARITY;
              end else begin
                r_bit_cnt <= r_bit_cnt + BCW'(1);
              end
            end else begin
              r_s_cnt <= r_s_cnt + SCW'(1);
            end
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            if (r_s_cnt == FULL_LAST) begin
              r_s_cnt   <= '0;
              r_par_bit <= w_line;
              r_state   <= S_STOP;
            end else begin
              r_s_cnt <= r_s_cnt + SCW'(1);
            end
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (r_s_cnt == FULL_LAST) begin
              r_s_cnt <= '0;
              if (!w_line) begin
                // Framing error wins over parity; wait out a break before rearming.
                r_err_frame <= 1'b1;
                r_state     <= S_WAIT_HI;
              end else begin
                r_state <= S_IDLE;
                if (w_par_ok) begin
                  r_good <= 1'b1;
                end else begin
                  r_err_parity <= 1'b1;
                end
              end
            end else begin
              r_s_cnt <= r_s_cnt + SCW'(1);
            end
          end
        end
        S_WAIT_HI: begin
          if (w_line) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_accept = r_rx_valid && rx_if.rx_ready;

  // Output buffer and LED register. r_shift still holds the finished payload
  // here because the next frame cannot shift in a data bit for at least a
  // start bit. A consumer accepting in the same cycle frees the slot, so the
  // new payload is loaded instead of being counted as an overrun.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_err_overrun <= 1'b0;
      r_led         <= '0;
    end else begin
      r_err_overrun <= 1'b0;
      if (r_good) begin
        r_led <= r_shift[NUM_LEDS-1:0];
        if (!r_rx_valid || rx_if.rx_ready) begin
          r_rx_data  <= r_shift;
          r_rx_valid <= 1'b1;
        end else begin
          r_err_overrun <= 1'b1;
        end
      end else if (w_accept) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data  = r_rx_data;
  assign rx_if.rx_valid = r_rx_valid;
  assign o_err_frame    = r_err_frame;
  assign o_err_parity   = r_err_parity;
  assign o_err_overrun  = r_err_overrun;
  assign o_led          = r_led;

endmodule
